button_press_classifier: RTL
============================

# button_press_classifier

Consumes the debounced button level produced by the debouncer stage and classifies each press as short, long or double. It emits one-cycle event pulses to downstream control logic, plus a level flag while a long hold persists. Purely synchronous to the system clock; the input is already debounced and synchronous, so there is no input synchronizer.

## Interface

- `LONG_CYCLES`, default 50_000_000: consecutive high samples that make a press "long"; minimum 2.
- `GAP_CYCLES`, default 12_500_000: consecutive low samples after a short release before the press is declared single; minimum 2.
- `CNT_W`, default 26: counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES).
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `s` input 1: debounced button level from the debouncer stage; 1 = pressed.
- `short_pulse` output 1: one-cycle pulse for a completed short, single press.
- `long_pulse` output 1: one-cycle pulse when a press reaches `LONG_CYCLES`.
- `double_pulse` output 1: one-cycle pulse on release of the second press of a double click.
- `held` output 1: level, high while in LONG_HELD.

## Operation

- All outputs are registered. Reset value is 0 for every output, `ARM` for state and 0 for the counter.
- States: `ARM`, `IDLE`, `PRESSED`, `LONG_HELD`, `WAIT_SECOND`, `SECOND_PRESS`.
- `ARM`: ignores `s` until it samples `s`=0, then goes to `IDLE`. A button held through reset release produces no event.
- `IDLE`: `s`=1 goes to `PRESSED` with cnt=1.
- `PRESSED`:
  - `s`=1 and cnt==`LONG_CYCLES`-1: pulse `long_pulse`, go to `LONG_HELD`.
  - `s`=1 otherwise: cnt+1.
  - `s`=0: go to `WAIT_SECOND` with cnt=1.
- `LONG_HELD`: `held`=1. `s`=0 goes to `IDLE`. A long press never produces a short or double event.
- `WAIT_SECOND`:
  - `s`=0 and cnt==`GAP_CYCLES`-1: pulse `short_pulse`, go to `IDLE`.
  - `s`=0 otherwise: cnt+1.
  - `s`=1: go to `SECOND_PRESS`.
- `SECOND_PRESS`: `s`=0 pulses `double_pulse` and goes to `IDLE`. Duration of the second press is not timed, so no long detection applies.
- The counter saturates by construction and never wraps. It clears on every state entry that loads it.
- At most one of the three pulses is high in any cycle.

## Timing

- Event latency is one cycle: a pulse is high exactly in the cycle following the clock edge that sampled the deciding `s` value.
- Long press: `s` high for `LONG_CYCLES` consecutive edges. `long_pulse` follows the `LONG_CYCLES`-th edge, and `held` rises in the same cycle.
- Short press: after release, `s` low for `GAP_CYCLES` consecutive edges. `short_pulse` follows the `GAP_CYCLES`-th low edge.
- A release on the same edge that would reach `LONG_CYCLES` does not occur, because that edge samples `s`=0; the release path wins.
- `rst_n` assertion at any time forces all outputs to 0 immediately and the state to `ARM`. Any partially classified press is discarded.

## Configuration

- `BUTTON_PRESS_CLASSIFIER_DOUBLE_EN`:
  - Defined: behaviour as above.
  - Undefined: `WAIT_SECOND` and `SECOND_PRESS` are not compiled in, and `double_pulse` is tied to 0. In `PRESSED`, `s`=0 pulses `short_pulse` and goes to `IDLE`, so short latency is one cycle after the release edge.

## Test plan

All scenarios use `LONG_CYCLES`=8, `GAP_CYCLES`=4 and the macro defined unless stated.

- Reset released with `s`=1 held for 20 cycles, then low: no pulse. A subsequent 3-cycle press followed by 4 low cycles gives `short_pulse` once, one cycle after the 4th low edge.
- `s` high for 8 edges: `long_pulse` after the 8th edge and `held`=1. Releasing after 30 more cycles gives `held`=0 and no short or double pulse.
- Press for 3 cycles, low for 2, press for 2, release: `double_pulse` once, one cycle after the release edge. No `short_pulse`.
- Press for 3 cycles, low for exactly 3, then press: classified as double, not short. Low for 4 instead: `short_pulse`, then the new press starts a fresh classification.
- `rst_n` pulsed low during the 5th cycle of a press: outputs are 0 asynchronously and no event follows until `s` is seen low.
- Macro undefined, 3-cycle press: `short_pulse` one cycle after the release edge, and `double_pulse` is constant 0 across all of the above stimulus.

Source files
------------

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short, long or double and emits
// one-cycle event pulses plus a level flag while a long hold persists.
//
// Parameters:
//   LONG_CYCLES : consecutive high samples that make a press long (>= 2)
//   GAP_CYCLES  : consecutive low samples after a short release before the
//                 press is declared single (>= 2)
//   CNT_W       : counter width, 2**CNT_W > max(LONG_CYCLES, GAP_CYCLES)
//
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   s            : debounced button level, 1 = pressed
//   short_pulse  : one-cycle pulse for a completed single short press
//   long_pulse   : one-cycle pulse when a press reaches LONG_CYCLES
//   double_pulse : one-cycle pulse on release of the second click
//   held         : high while a long press is still being held
//
// Build option:
//   BUTTON_PRESS_CLASSIFIER_DOUBLE_EN : when defined, double-click detection
//   is compiled in. When undefined, a short press is reported one cycle
//   after its release and double_pulse is tied to 0.

module button_press_classifier #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        ARM          = 3'd0,
        IDLE         = 3'd1,
        PRESSED      = 3'd2,
        LONG_HELD    = 3'd3
`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
        ,
        WAIT_SECOND  = 3'd4,
        SECOND_PRESS = 3'd5
`endif
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Elaboration-time sanity checks on the configuration.
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_bad_cycles
        $error("LONG_CYCLES and GAP_CYCLES must be at least 2");
    end
    if (CNT_W < 31 &&
        ((64'(1) << CNT_W) <= 64'(LONG_CYCLES) ||
         (64'(1) << CNT_W) <= 64'(GAP_CYCLES))) begin : g_bad_width
        $error("CNT_W too small for LONG_CYCLES/GAP_CYCLES");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    logic             dbl_q, dbl_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
        dbl_d   = 1'b0;
`endif
        unique case (state_q)
            // A button held through reset release must be let go first.
            ARM: begin
                if (!s) state_d = IDLE;
            end
            IDLE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ONE;
                end
            end
            // The release path has priority over reaching LONG_CYCLES.
            PRESSED: begin
                if (s) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG_HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
                    state_d = WAIT_SECOND;
                    cnt_d   = CNT_ONE;
`else
                    short_d = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            LONG_HELD: begin
                if (!s) state_d = IDLE;
            end
`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
            WAIT_SECOND: begin
                if (s) begin
                    state_d = SECOND_PRESS;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Second press is not timed; only its release matters.
            SECOND_PRESS: begin
                if (!s) begin
                    dbl_d   = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = ARM;
        endcase
        // held is registered from the next state so it rises with long_pulse.
        held_d = (state_d == LONG_HELD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARM;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

`ifdef BUTTON_PRESS_CLASSIFIER_DOUBLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbl_q <= 1'b0;
        else        dbl_q <= dbl_d;
    end
    assign double_pulse = dbl_q;
`else
    assign double_pulse = 1'b0;
`endif

    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign held        = held_q;

endmodule
